pwm_counter_gen: RTL and testbench
==================================

// Module: pwm_counter_gen
// PURPOSE
//   Upstream feeder for the PWM comparator stage: generates its prescaled DATA-bit sawtooth counter.
//   Also supplies a glitch-free duty value: sw_in is synchronised and latched only at period boundaries.
//   Outputs counter and duty_out connect directly to the comparator's counter and sw inputs.
// PARAMETERS
//   DATA      4       counter width in bits; period = 2**DATA ticks
//   PRESCALE  50000   clk cycles per counter tick; legal range >=1; 1 = tick every enabled cycle
// PORTS
//   clk       in   1     system clock; all logic on its rising edge
//   rst       in   1     asynchronous reset, active-low
//   en        in   1     count enable (synchronous to clk)
//   sw_in     in   4     raw duty switches (asynchronous)
//   counter   out  DATA  PWM ramp value to comparator
//   duty_out  out  4     period-aligned duty value to comparator sw
//   tick      out  1     one-cycle pulse on each counter advance
//   wrap      out  1     one-cycle pulse on period start; duty_out updated on the same cycle
// BEHAVIOUR
//   - Reset (rst=0): async clear of prescaler, counter, duty_out, tick, wrap and sync flops to 0.
//     Reset also sets direction to up. Takes effect immediately, mid-operation included.
//     First tick after release comes exactly PRESCALE enabled cycles later.
//   - Prescaler: width max(1,$clog2(PRESCALE)); counts 0..PRESCALE-1 while en=1.
//     On the edge where prescaler==PRESCALE-1 && en: prescaler<=0, counter advances, tick<=1.
//     On every other edge tick<=0.
//   - Counter: advances +1 per tick, modulo 2**DATA. 2**DATA-1 -> 0 wraps with no gap.
//   - Wrap: on the edge where a tick moves counter from 2**DATA-1 to 0, wrap<=1 and duty_out<=sw_sync.
//     Otherwise wrap<=0 and duty_out holds. tick and wrap are high together on that cycle.
//   - sw_in passes through a 2-FF synchroniser to give sw_sync.
//     Any sw_in change waits at least 2 clk cycles plus the rest of the current period before reaching duty_out.
//   - en=0: prescaler, counter and duty_out hold; tick=wrap=0 from the next edge.
//     Re-assert resumes from the held prescaler value; no count is lost or repeated.
//   - All outputs registered; no combinational path from inputs to outputs.
// CONFIGURATION
//   PWM_CENTER_ALIGNED_EN defined:
//     - Up/down counter: counts 0..2**DATA-1, then down to 0.
//     - Direction flips at the extremes; each extreme value is held for one tick only.
//     - Period = 2*(2**DATA-1) ticks; wrap fires only on the tick that reaches 0 while counting down.
//     - Reset starts counting up from 0 with no wrap at startup.
//   PWM_CENTER_ALIGNED_EN undefined:
//     - Sawtooth behaviour as above; no direction flop is synthesised.
// STRUCTURE
//   - Shared package pwm_pkg:
//     - DATA default width constant.
//     - duty_t typedef (4-bit duty code).
//     - COUNT_MAX function (2**DATA-1); shared with the comparator.
//   - One sub-module pwm_prescaler (PRESCALE, clk, rst, en -> tick): it is reusable for other timed blocks.
//   - Synchroniser, counter, direction and shadow register stay inline.
// TESTING  (DATA=4, PRESCALE=4 unless noted)
//   1 Reset: rst=0 -> all outputs 0. Release rst with en=1 -> tick on 4th cycle, counter 0->1, wrap=0.
//   2 Wrap/load: sw_in=4'b0101 held. After 16 ticks counter 15->0.
//     wrap and tick high for exactly one cycle; duty_out=5 on that cycle.
//   3 Shadowing: duty_out=5; sw_in 5->9 at counter=7. duty_out stays 5 through counter 8..15.
//     duty_out becomes 9 at next wrap.
//   4 Enable: drop en at counter=6 for 20 cycles -> counter holds 6, tick=wrap=0.
//     Re-assert -> next tick after remaining prescale count, counter=7.
//   5 Async reset mid-count: rst low between edges at counter=10.
//     Outputs 0 before next clk edge; no wrap pulse.
//   6 PRESCALE=1 with PWM_CENTER_ALIGNED_EN: counter 0,1..15,14..1,0 on consecutive enabled cycles.
//     wrap only on return to 0; period 30 cycles.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM counter generator and the comparator it feeds.
package pwm_pkg;

    localparam int DATA_DEFAULT = 4;

    typedef logic [3:0] duty_t;

    // Top value of a data-bit counter, i.e. 2**data - 1.
    function automatic int unsigned COUNT_MAX(input int unsigned data);
        return (32'd1 << data) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Reusable clock prescaler: emits a registered one-cycle tick every PRESCALE enabled cycles.
// The combinational advance strobe lets a client update state on the same edge that tick rises.
module pwm_prescaler #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick,
    output logic advance
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] STEP = PW'(1);

    logic [PW-1:0] count_r;

    assign advance = en && (count_r == LAST);

    // Prescale count and registered tick pulse; the count holds while en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
            tick    <= 1'b0;
        end else if (advance) begin
            count_r <= '0;
            tick    <= 1'b1;
        end else if (en) begin
            count_r <= count_r + STEP;
            tick    <= 1'b0;
        end else begin
            count_r <= count_r;
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/pwm_counter_gen.sv
// PWM ramp counter plus period-aligned duty shadow register feeding the comparator stage.
// Define PWM_CENTER_ALIGNED_EN for an up/down (center-aligned) ramp instead of a sawtooth.
module pwm_counter_gen
    import pwm_pkg::*;
#(
    parameter int DATA     = DATA_DEFAULT,
    parameter int PRESCALE = 50000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  duty_t           sw_in,
    output logic [DATA-1:0] counter,
    output duty_t           duty_out,
    output logic            tick,
    output logic            wrap
);

    localparam logic [DATA-1:0] CNT_MAX = DATA'(COUNT_MAX(DATA));
    localparam logic [DATA-1:0] CNT_ONE = DATA'(1);

    logic            advance_s;
    logic [DATA-1:0] counter_next_s;
    logic            wrap_next_s;
    duty_t           sync1_r;
    duty_t           sync2_r;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .tick    (tick),
        .advance (advance_s)
    );

    // Two-flop synchroniser for the asynchronous duty switches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= sw_in;
            sync2_r <= sync1_r;
        end
    end

`ifdef PWM_CENTER_ALIGNED_EN
    logic dir_up_r;
    logic dir_up_next_s;

    // Up/down ramp: each extreme is visited for one tick, wrap on reaching 0 going down.
    always_comb begin
        counter_next_s = counter;
        wrap_next_s    = 1'b0;
        dir_up_next_s  = dir_up_r;
        if (advance_s) begin
            if (dir_up_r) begin
                if (counter == CNT_MAX) begin
                    counter_next_s = counter - CNT_ONE;
                    dir_up_next_s  = 1'b0;
                end else begin
                    counter_next_s = counter + CNT_ONE;
                end
            end else begin
                if (counter == CNT_ONE) begin
                    counter_next_s = '0;
                    wrap_next_s    = 1'b1;
                    dir_up_next_s  = 1'b1;
                end else begin
                    counter_next_s = counter - CNT_ONE;
                end
            end
        end else begin
            counter_next_s = counter;
        end
    end

    // Direction flop; reset always starts counting up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_up_r <= 1'b1;
        end else begin
            dir_up_r <= dir_up_next_s;
        end
    end
`else
    // Sawtooth ramp: modulo increment, wrap on the MAX -> 0 step.
    always_comb begin
        counter_next_s = counter;
        wrap_next_s    = 1'b0;
        if (advance_s) begin
            counter_next_s = counter + CNT_ONE;
            wrap_next_s    = (counter == CNT_MAX);
        end else begin
            counter_next_s = counter;
        end
    end
`endif

    // Counter, wrap pulse and duty shadow register (loaded only at period start).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter  <= '0;
            wrap     <= 1'b0;
            duty_out <= '0;
        end else begin
            counter <= counter_next_s;
            wrap    <= wrap_next_s;
            if (wrap_next_s) begin
                duty_out <= sync2_r;
            end else begin
                duty_out <= duty_out;
            end
        end
    end

endmodule

// File: tb/tb_pwm_counter_gen.sv
// Directed self-checking bench: unit A (DATA=4, PRESCALE=4) and unit B (DATA=4, PRESCALE=1).
// Unit B checks the center-aligned ramp when PWM_CENTER_ALIGNED_EN is defined, else the sawtooth.
module tb_pwm_counter_gen;

    logic       clk = 1'b0;
    logic       rst_a, en_a, rst_b, en_b;
    logic [3:0] sw_a, sw_b;
    logic [3:0] counter_a, duty_a, counter_b, duty_b;
    logic       tick_a, wrap_a, tick_b, wrap_b;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pwm_counter_gen #(.DATA(4), .PRESCALE(4)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .sw_in(sw_a),
        .counter(counter_a), .duty_out(duty_a), .tick(tick_a), .wrap(wrap_a)
    );

    pwm_counter_gen #(.DATA(4), .PRESCALE(1)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .sw_in(sw_b),
        .counter(counter_b), .duty_out(duty_b), .tick(tick_b), .wrap(wrap_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b0; en_a = 1'b0; sw_a = 4'd0;
        rst_b = 1'b0; en_b = 1'b0; sw_b = 4'd0;
        run(2);
        check("rst_counter", {28'd0, counter_a}, 32'd0);
        check("rst_duty",    {28'd0, duty_a},    32'd0);
        check("rst_tick",    {31'd0, tick_a},    32'd0);
        check("rst_wrap",    {31'd0, wrap_a},    32'd0);

        // Release with en=1: first tick on the 4th edge.
        en_a = 1'b1; sw_a = 4'b0101;
        rst_a = 1'b1;
        run(3);
        check("pre_tick",     {31'd0, tick_a},    32'd0);
        check("pre_counter",  {28'd0, counter_a}, 32'd0);
        run(1);
        check("first_tick",   {31'd0, tick_a},    32'd1);
        check("first_count",  {28'd0, counter_a}, 32'd1);
        check("first_wrap",   {31'd0, wrap_a},    32'd0);

        // Wrap and duty load.
        run(56);
        check("cnt15",        {28'd0, counter_a}, 32'd15);
        check("cnt15_tick",   {31'd0, tick_a},    32'd1);
        check("cnt15_wrap",   {31'd0, wrap_a},    32'd0);
        run(3);
        check("cnt15_hold",   {28'd0, counter_a}, 32'd15);
        run(1);
        check("wrap_counter", {28'd0, counter_a}, 32'd0);
        check("wrap_tick",    {31'd0, tick_a},    32'd1);
        check("wrap_pulse",   {31'd0, wrap_a},    32'd1);
        check("wrap_duty",    {28'd0, duty_a},    32'd5);
        run(1);
        check("wrap_1cyc",    {31'd0, wrap_a},    32'd0);
        check("tick_1cyc",    {31'd0, tick_a},    32'd0);

        // Shadowing: change switches mid-period.
        run(27);
        check("cnt7",         {28'd0, counter_a}, 32'd7);
        sw_a = 4'b1001;
        run(4);
        check("cnt8",         {28'd0, counter_a}, 32'd8);
        check("shadow_8",     {28'd0, duty_a},    32'd5);
        run(28);
        check("cnt15_b",      {28'd0, counter_a}, 32'd15);
        check("shadow_15",    {28'd0, duty_a},    32'd5);
        run(4);
        check("wrap2_pulse",  {31'd0, wrap_a},    32'd1);
        check("wrap2_duty",   {28'd0, duty_a},    32'd9);

        // Enable gap at counter 6 with prescaler at 1.
        run(24);
        check("cnt6",         {28'd0, counter_a}, 32'd6);
        run(1);
        en_a = 1'b0;
        run(20);
        check("hold_counter", {28'd0, counter_a}, 32'd6);
        check("hold_tick",    {31'd0, tick_a},    32'd0);
        check("hold_wrap",    {31'd0, wrap_a},    32'd0);
        en_a = 1'b1;
        run(2);
        check("resume_early", {31'd0, tick_a},    32'd0);
        check("resume_cnt6",  {28'd0, counter_a}, 32'd6);
        run(1);
        check("resume_tick",  {31'd0, tick_a},    32'd1);
        check("resume_cnt7",  {28'd0, counter_a}, 32'd7);

        // Async reset between edges at counter 10.
        run(12);
        check("cnt10",        {28'd0, counter_a}, 32'd10);
        #2 rst_a = 1'b0;
        #1;
        check("arst_counter", {28'd0, counter_a}, 32'd0);
        check("arst_duty",    {28'd0, duty_a},    32'd0);
        check("arst_tick",    {31'd0, tick_a},    32'd0);
        check("arst_wrap",    {31'd0, wrap_a},    32'd0);
        run(1);
        check("arst_nowrap",  {31'd0, wrap_a},    32'd0);
        rst_a = 1'b1;
        run(3);
        check("rel2_pre",     {31'd0, tick_a},    32'd0);
        run(1);
        check("rel2_tick",    {31'd0, tick_a},    32'd1);
        check("rel2_count",   {28'd0, counter_a}, 32'd1);

        // PRESCALE=1: a tick on every enabled cycle.
        sw_b = 4'd3; en_b = 1'b1;
        rst_b = 1'b1;
`ifdef PWM_CENTER_ALIGNED_EN
        for (int k = 1; k <= 31; k++) begin
            int ph;
            run(1);
            ph = k % 30;
            check("ca_counter", {28'd0, counter_b}, (ph <= 15) ? ph : 30 - ph);
            check("ca_wrap",    {31'd0, wrap_b},    (ph == 0) ? 32'd1 : 32'd0);
            check("ca_tick",    {31'd0, tick_b},    32'd1);
            check("ca_duty",    {28'd0, duty_b},    (k >= 30) ? 32'd3 : 32'd0);
        end
`else
        for (int k = 1; k <= 33; k++) begin
            run(1);
            check("st_counter", {28'd0, counter_b}, k % 16);
            check("st_wrap",    {31'd0, wrap_b},    (k % 16 == 0) ? 32'd1 : 32'd0);
            check("st_tick",    {31'd0, tick_b},    32'd1);
            check("st_duty",    {28'd0, duty_b},    (k >= 16) ? 32'd3 : 32'd0);
        end
`endif
        en_b = 1'b0;
        run(1);
        check("b_en_off_tick", {31'd0, tick_b}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
